nkmd_ddr3_dma: RTL and testbench
================================

NKMD_DDR3_DMA -- requirements
Module: nkmd_ddr3_dma

Interface
- REQ-001: Parameter BUF_AW, default 8, log2 of local buffer depth in 32-bit words (256 words).
- REQ-002: Parameter MAX_BL, default 64, maximum burst length in words; SHALL be at most 64.
- REQ-003: clk  input  1  sole clock; all logic on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: data_i  input  32  nkmd bus write data.
- REQ-006: data_o  output  32  nkmd bus read data, registered.
- REQ-007: addr_i  input  16  nkmd bus word address.
- REQ-008: we_i  input  1  nkmd bus write strobe, one write per cycle high.
- REQ-009: mig_cmd_en  output  1; mig_cmd_instr  output  3; mig_cmd_bl  output  6; mig_cmd_byte_addr  output  30.
- REQ-010: mig_cmd_empty, mig_cmd_full  input  1 each.
- REQ-011: mig_wr_en  output  1; mig_wr_data  output  32; mig_wr_mask  output  4 (always 0).
- REQ-012: mig_wr_full, mig_wr_empty  input  1 each; mig_wr_count  input  7.
- REQ-013: mig_rd_en  output  1; mig_rd_data  input  32; mig_rd_empty  input  1; mig_rd_count  input  7.

Function
- REQ-014: Buffer window 0x1000 + (0..2^BUF_AW-1); bus writes store data_i, bus reads return word; addresses above window not decoded as buffer.
- REQ-015: Registers: 0xc100 DDR byte address (bits[1:0] forced 0); 0xc101 buffer start offset (BUF_AW bits); 0xc102 burst length minus 1 (6 bits); 0xc103 write = launch, data_i[0]=1 write-to-DDR, 0 read-from-DDR; 0xc104 status.
- REQ-016: Status read value: bit0 busy, bit1 error, bits[15:8] completed-transfer count (wraps 255->0); bus write to 0xc104 clears error only.
- REQ-017: Registers 0xc100-0xc102 readable; writes while busy are ignored.
- REQ-018: data_o SHALL reflect addr_i of the previous cycle (one-cycle registered read latency); unmapped addresses return 0.
- REQ-019: States IDLE, WR_PUSH, WR_CMD, RD_CMD, RD_POP.
- REQ-020: Launch in IDLE with bl+1 > MAX_BL: no transfer, error set, stay IDLE.
- REQ-021: Launch write: IDLE->WR_PUSH; each cycle with !mig_wr_full pop buffer[offset+i] to mig_wr_data with mig_wr_en high; after bl+1 words ->WR_CMD.
- REQ-022: WR_CMD: assert mig_cmd_en for exactly one cycle when !mig_cmd_full, instr=3'b000, bl=programmed bl, byte_addr=programmed address; then ->IDLE, done count +1.
- REQ-023: Launch read: IDLE->RD_CMD; one-cycle mig_cmd_en with instr=3'b001 when !mig_cmd_full; ->RD_POP.
- REQ-024: RD_POP: each cycle with !mig_rd_empty assert mig_rd_en and store mig_rd_data to buffer[offset+i]; after bl+1 words ->IDLE, done count +1.
- REQ-025: Buffer index offset+i wraps modulo 2^BUF_AW.
- REQ-026: Launch while busy: ignored, error set, current transfer unaffected.
- REQ-027: Bus write to buffer during transfer is permitted; in same cycle as RD_POP write to same index, RD_POP data wins.
- REQ-028: busy=1 in every state except IDLE.
- REQ-029: mig_wr_en and mig_rd_en never asserted when respective full/empty input high; mig_cmd_en never asserted when mig_cmd_full high.

Reset
- REQ-030: rst forces IDLE; registers, done count, error, data_o, all mig enables to 0; buffer contents undefined.
- REQ-031: rst mid-transfer aborts immediately; no further mig strobes in the cycle after rst sampled.

Verification
- REQ-032: Fill 0x1080-0x1087 with 1..8, 0xc100=0x0abcdefc, 0xc101=0x80, 0xc102=7, 0xc103=1, fifos never full -> 8 wr_en beats data 1..8, one cmd_en instr 0 bl 7 addr 0x0abcdefc, status 0x0100.
- REQ-033: 0xc100=0xadadadad, 0xc101=0xc0, 0xc102=1, 0xc103=0; rd_empty deasserted two cycles with data 0xdeadbeef,0xcafebabe -> cmd_en instr 1 addr 0xadadadac, reads 0x10c0=deadbeef, 0x10c1=cafebabe.
- REQ-034: Write burst with mig_wr_full held high 5 cycles mid-burst -> no wr_en while full, all words delivered in order.
- REQ-035: Offset 0xfe, bl 3, read -> data lands at 0x10fe,0x10ff,0x1000,0x1001.
- REQ-036: 0xc102=0x3f with MAX_BL=32 launch -> error bit set, no mig strobes; write 0xc104 -> status bit1 0.
- REQ-037: rst asserted during RD_POP -> mig_rd_en low next cycle, status reads 0.

Source files
------------

// File: rtl/nkmd_ddr3_dma.sv
// nkmd bus slave that moves bursts between a local word buffer and the
// user port of a DDR3 MIG (command, write-data and read-data FIFOs).
module nkmd_ddr3_dma #(
    parameter int BUF_AW = 8,
    parameter int MAX_BL = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [15:0] addr_i,
    input  logic        we_i,
    output logic        mig_cmd_en,
    output logic [2:0]  mig_cmd_instr,
    output logic [5:0]  mig_cmd_bl,
    output logic [29:0] mig_cmd_byte_addr,
    input  logic        mig_cmd_empty,
    input  logic        mig_cmd_full,
    output logic        mig_wr_en,
    output logic [31:0] mig_wr_data,
    output logic [3:0]  mig_wr_mask,
    input  logic        mig_wr_full,
    input  logic        mig_wr_empty,
    input  logic [6:0]  mig_wr_count,
    output logic        mig_rd_en,
    input  logic [31:0] mig_rd_data,
    input  logic        mig_rd_empty,
    input  logic [6:0]  mig_rd_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_PUSH,
        WR_CMD,
        RD_CMD,
        RD_POP
    } state_t;

    localparam logic [15:0] A_DDR_ADDR = 16'hc100;
    localparam logic [15:0] A_OFFSET   = 16'hc101;
    localparam logic [15:0] A_BL       = 16'hc102;
    localparam logic [15:0] A_LAUNCH   = 16'hc103;
    localparam logic [15:0] A_STATUS   = 16'hc104;
    localparam logic [16:0] WIN_BASE   = 17'h01000;
    localparam logic [16:0] WIN_END    = WIN_BASE + 17'(2 ** BUF_AW);
    localparam logic [6:0]  MAX_BL_W   = 7'(MAX_BL);

    state_t              state_q, state_d;
    logic [31:0]         ddr_addr_q, ddr_addr_d;
    logic [BUF_AW-1:0]   off_q, off_d;
    logic [5:0]          bl_q, bl_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [7:0]          done_q, done_d;
    logic [31:0]         data_o_q, data_o_d;

    logic [31:0]         buf_mem [2 ** BUF_AW];
    logic                buf_hit;
    logic [BUF_AW-1:0]   bus_idx;
    logic [BUF_AW-1:0]   xfer_idx;
    logic                busy;
    logic                launch;

    logic unused_inputs;
    assign unused_inputs = ^{mig_cmd_empty, mig_wr_empty, mig_wr_count, mig_rd_count};

    assign buf_hit  = ({1'b0, addr_i} >= WIN_BASE) && ({1'b0, addr_i} < WIN_END);
    assign bus_idx  = addr_i[BUF_AW-1:0];
    // Burst index wraps naturally at the buffer size.
    assign xfer_idx = off_q + BUF_AW'(cnt_q);
    assign busy     = (state_q != IDLE);
    assign launch   = we_i && (addr_i == A_LAUNCH);

    assign data_o            = data_o_q;
    assign mig_cmd_bl        = bl_q;
    assign mig_cmd_byte_addr = ddr_addr_q[29:0];
    assign mig_wr_data       = buf_mem[xfer_idx];
    assign mig_wr_mask       = 4'b0000;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d       = state_q;
        ddr_addr_d    = ddr_addr_q;
        off_d         = off_q;
        bl_d          = bl_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        done_d        = done_q;
        data_o_d      = 32'h0;
        mig_cmd_en    = 1'b0;
        mig_cmd_instr = 3'b000;
        mig_wr_en     = 1'b0;
        mig_rd_en     = 1'b0;

        if (we_i && !busy) begin
            case (addr_i)
                A_DDR_ADDR: ddr_addr_d = {data_i[31:2], 2'b00};
                A_OFFSET:   off_d      = data_i[BUF_AW-1:0];
                A_BL:       bl_d       = data_i[5:0];
                default:    ;
            endcase
        end
        if (we_i && (addr_i == A_STATUS)) err_d = 1'b0;
        if (launch && busy) err_d = 1'b1;

        if (buf_hit) begin
            data_o_d = buf_mem[bus_idx];
        end else begin
            case (addr_i)
                A_DDR_ADDR: data_o_d = ddr_addr_q;
                A_OFFSET:   data_o_d = 32'(off_q);
                A_BL:       data_o_d = {26'h0, bl_q};
                A_STATUS:   data_o_d = {16'h0, done_q, 6'h0, err_q, busy};
                default:    data_o_d = 32'h0;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    if (({1'b0, bl_q} + 7'd1) > MAX_BL_W) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = 6'd0;
                        state_d = data_i[0] ? WR_PUSH : RD_CMD;
                    end
                end
            end
            WR_PUSH: begin
                if (!mig_wr_full) begin
                    mig_wr_en = 1'b1;
                    if (cnt_q == bl_q) state_d = WR_CMD;
                    else               cnt_d   = cnt_q + 6'd1;
                end
            end
            WR_CMD: begin
                if (!mig_cmd_full) begin
                    mig_cmd_en = 1'b1;
                    done_d     = done_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            RD_CMD: begin
                mig_cmd_instr = 3'b001;
                if (!mig_cmd_full) begin
                    mig_cmd_en = 1'b1;
                    cnt_d      = 6'd0;
                    state_d    = RD_POP;
                end
            end
            RD_POP: begin
                if (!mig_rd_empty) begin
                    mig_rd_en = 1'b1;
                    if (cnt_q == bl_q) begin
                        done_d  = done_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer being reset must not pop or push anything more.
        if (rst) begin
            mig_cmd_en = 1'b0;
            mig_wr_en  = 1'b0;
            mig_rd_en  = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ddr_addr_q <= 32'h0;
            off_q      <= '0;
            bl_q       <= 6'd0;
            cnt_q      <= 6'd0;
            err_q      <= 1'b0;
            done_q     <= 8'd0;
            data_o_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            ddr_addr_q <= ddr_addr_d;
            off_q      <= off_d;
            bl_q       <= bl_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            data_o_q   <= data_o_d;
        end
    end

    // NOTE: the buffer has no reset; its contents are don't-care until written.
    // The DDR read port is written last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (we_i && buf_hit) buf_mem[bus_idx] <= data_i;
        if (mig_rd_en)       buf_mem[xfer_idx] <= mig_rd_data;
    end

endmodule

// File: tb/tb_nkmd_ddr3_dma.sv
// Randomized self-checking bench for nkmd_ddr3_dma: MIG FIFOs are modelled with
// queues and the buffer/register file with a plain array.
module tb_nkmd_ddr3_dma;

    localparam logic [15:0] C_ADDR = 16'hc100;
    localparam logic [15:0] C_OFF  = 16'hc101;
    localparam logic [15:0] C_BL   = 16'hc102;
    localparam logic [15:0] C_GO   = 16'hc103;
    localparam logic [15:0] C_STAT = 16'hc104;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic [15:0] addr_i = 16'h0;
    logic        we_i = 1'b0;
    logic        mig_cmd_en;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl;
    logic [29:0] mig_cmd_byte_addr;
    logic        mig_cmd_full = 1'b0;
    logic        mig_wr_en;
    logic [31:0] mig_wr_data;
    logic [3:0]  mig_wr_mask;
    logic        mig_wr_full = 1'b0;
    logic        mig_rd_en;
    logic [31:0] mig_rd_data = 32'h0;
    logic        mig_rd_empty = 1'b1;

    nkmd_ddr3_dma #(.BUF_AW(8), .MAX_BL(32)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .data_o(data_o),
        .addr_i(addr_i), .we_i(we_i),
        .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
        .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_empty(1'b1), .mig_cmd_full(mig_cmd_full),
        .mig_wr_en(mig_wr_en), .mig_wr_data(mig_wr_data), .mig_wr_mask(mig_wr_mask),
        .mig_wr_full(mig_wr_full), .mig_wr_empty(1'b1), .mig_wr_count(7'd0),
        .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data), .mig_rd_empty(mig_rd_empty),
        .mig_rd_count(7'd0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } cmd_t;

    cmd_t        cmd_seen[$];
    logic [31:0] wr_seen[$];
    logic [31:0] rd_src[$];
    logic [31:0] rd_plan[$];
    logic [31:0] exp_wr[$];
    int          viol = 0;
    int          rd_pops = 0;
    logic        force_wr_full = 1'b0;
    logic        stall_en = 1'b0;

    // Reference state: buffer image, programmed registers, status fields.
    logic [31:0] mbuf [256];
    logic [31:0] m_addr = 32'h0;
    logic [7:0]  m_off = 8'h0;
    logic [5:0]  m_bl = 6'h0;
    logic [7:0]  m_done = 8'h0;
    logic        m_err = 1'b0;
    logic        m_dir = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // MIG FIFO model: inputs change on the falling edge, strobes are
    // sampled just after, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        cmd_t c;
        mig_wr_full  = force_wr_full || (stall_en && ($urandom_range(0, 3) == 0));
        mig_cmd_full = stall_en && ($urandom_range(0, 3) == 0);
        mig_rd_empty = (rd_src.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
        mig_rd_data  = (rd_src.size() != 0) ? rd_src[0] : 32'h0;
        #1;
        if ((mig_wr_en && mig_wr_full) || (mig_cmd_en && mig_cmd_full) ||
            (mig_rd_en && mig_rd_empty)) viol++;
        if (mig_wr_en) wr_seen.push_back(mig_wr_data);
        if (mig_cmd_en) begin
            c.instr = mig_cmd_instr;
            c.bl    = mig_cmd_bl;
            c.addr  = mig_cmd_byte_addr;
            cmd_seen.push_back(c);
        end
        if (mig_rd_en) begin
            rd_pops++;
            if (rd_src.size() != 0) void'(rd_src.pop_front());
        end
    end

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        we_i   = 1'b0;
        @(negedge clk);
        d = data_o;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            we_i = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        return {16'h0, m_done, 6'h0, m_err, busy};
    endfunction

    task automatic buf_wr(input logic [7:0] idx, input logic [31:0] d);
        bus_wr(16'h1000 + {8'h0, idx}, d);
        mbuf[idx] = d;
    endtask

    task automatic prog(input logic [31:0] a, input logic [7:0] off, input logic [5:0] bl);
        bus_wr(C_ADDR, a);
        bus_wr(C_OFF, {24'h0, off});
        bus_wr(C_BL, {26'h0, bl});
        m_addr = {a[31:2], 2'b00};
        m_off  = off;
        m_bl   = bl;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n = 0;
        do begin
            bus_rd(C_STAT, s);
            n++;
        end while (s[0] && n < 3000);
        check({tag, "_idle"}, {31'h0, s[0]}, 32'h0);
    endtask

    task automatic start_xfer(input logic to_ddr);
        wr_seen.delete();
        cmd_seen.delete();
        exp_wr.delete();
        viol    = 0;
        rd_pops = 0;
        m_dir   = to_ddr;
        if (to_ddr) begin
            for (int i = 0; i <= int'(m_bl); i++) exp_wr.push_back(mbuf[m_off + 8'(i)]);
        end else begin
            if (rd_plan.size() == 0)
                for (int i = 0; i <= int'(m_bl); i++) rd_plan.push_back($urandom);
            foreach (rd_plan[i]) begin
                rd_src.push_back(rd_plan[i]);
                mbuf[m_off + 8'(i)] = rd_plan[i];
            end
            rd_plan.delete();
        end
        bus_wr(C_GO, {31'h0, to_ddr});
    endtask

    task automatic finish_xfer(input string tag);
        logic [31:0] d;
        wait_idle(tag);
        m_done++;
        check({tag, "_ncmd"}, 32'(cmd_seen.size()), 32'd1);
        if (cmd_seen.size() != 0) begin
            check({tag, "_instr"}, {29'h0, cmd_seen[0].instr}, m_dir ? 32'h0 : 32'h1);
            check({tag, "_bl"}, {26'h0, cmd_seen[0].bl}, {26'h0, m_bl});
            check({tag, "_addr"}, {2'b00, cmd_seen[0].addr}, {2'b00, m_addr[29:0]});
        end
        if (m_dir) begin
            check({tag, "_nwr"}, 32'(wr_seen.size()), 32'(exp_wr.size()));
            foreach (exp_wr[i])
                check({tag, "_wdata"}, (i < wr_seen.size()) ? wr_seen[i] : 32'hxxxxxxxx, exp_wr[i]);
        end else begin
            check({tag, "_nrd"}, 32'(rd_pops), 32'(m_bl) + 32'd1);
            for (int i = 0; i <= int'(m_bl); i++) begin
                bus_rd(16'h1000 + {8'h0, m_off + 8'(i)}, d);
                check({tag, "_rdbuf"}, d, mbuf[m_off + 8'(i)]);
            end
        end
        check({tag, "_viol"}, 32'(viol), 32'd0);
        bus_rd(C_STAT, d);
        check({tag, "_status"}, d, exp_status(1'b0));
    endtask

    task automatic bad_launch(input string tag);
        logic [31:0] d;
        cmd_seen.delete();
        wr_seen.delete();
        rd_pops = 0;
        bus_wr(C_GO, {31'h0, 1'($urandom_range(0, 1))});
        idle(6);
        m_err = 1'b1;
        check({tag, "_strobes"}, 32'(cmd_seen.size() + wr_seen.size() + rd_pops), 32'd0);
        bus_rd(C_STAT, d);
        check({tag, "_err"}, d, exp_status(1'b0));
        bus_wr(C_STAT, 32'h0);
        m_err = 1'b0;
        bus_rd(C_STAT, d);
        check({tag, "_clr"}, d, exp_status(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [5:0]  bl;
        foreach (mbuf[i]) mbuf[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'h0, mig_cmd_en, mig_wr_en, mig_rd_en}, 32'h0);
        check("rst_data_o", data_o, 32'h0);
        rst = 1'b0;
        bus_rd(C_STAT, d);  check("rst_status", d, 32'h0);
        bus_rd(C_ADDR, d);  check("rst_addr", d, 32'h0);
        bus_rd(C_OFF, d);   check("rst_off", d, 32'h0);
        bus_rd(C_BL, d);    check("rst_bl", d, 32'h0);
        bus_rd(16'hc105, d); check("unmapped", d, 32'h0);
        for (int i = 0; i < 256; i++) buf_wr(8'(i), 32'h5a000000 | 32'(i));
        bus_rd(16'h1100, d); check("above_window", d, 32'h0);
        bus_rd(16'h10ff, d); check("window_top", d, mbuf[8'hff]);

        // Directed write burst
        for (int i = 0; i < 8; i++) buf_wr(8'h80 + 8'(i), 32'(i + 1));
        prog(32'h0abcdefc, 8'h80, 6'd7);
        start_xfer(1'b1);
        finish_xfer("dir_wr");

        // Directed read burst with unaligned address
        rd_plan.push_back(32'hdeadbeef);
        rd_plan.push_back(32'hcafebabe);
        prog(32'hadadadad, 8'hc0, 6'd1);
        start_xfer(1'b0);
        finish_xfer("dir_rd");
        bus_rd(C_ADDR, d); check("addr_align", d, 32'hadadadac);

        // Write burst with write FIFO full mid-burst
        prog(32'h00001000, 8'h10, 6'd15);
        start_xfer(1'b1);
        idle(3);
        force_wr_full = 1'b1;
        idle(5);
        force_wr_full = 1'b0;
        finish_xfer("wr_full");

        // Read that wraps around the buffer end
        prog(32'h00002000, 8'hfe, 6'd3);
        start_xfer(1'b0);
        finish_xfer("rd_wrap");

        // Over-long burst
        prog(32'h00003000, 8'h00, 6'h3f);
        bad_launch("too_long");

        // Launch and register writes while busy
        prog(32'h12345678, 8'h20, 6'd3);
        force_wr_full = 1'b1;
        start_xfer(1'b1);
        bus_wr(C_GO, 32'h0);
        bus_wr(C_ADDR, 32'hffffffff);
        bus_wr(C_OFF, 32'h0);
        bus_wr(C_BL, 32'h1);
        m_err = 1'b1;
        bus_rd(C_STAT, d); check("busy_status", d, exp_status(1'b1));
        force_wr_full = 1'b0;
        finish_xfer("busy_launch");
        bus_rd(C_ADDR, d); check("busy_addr_kept", d, 32'h12345678);
        bus_wr(C_STAT, 32'h0);
        m_err = 1'b0;

        // Randomized transfers with random FIFO back-pressure
        stall_en = 1'b1;
        for (int t = 0; t < 24; t++) begin
            repeat (4) buf_wr(8'($urandom), $urandom);
            bl = 6'($urandom_range(0, 40));
            prog($urandom, 8'($urandom), bl);
            if (bl > 6'd31) begin
                bad_launch("rnd_bad");
            end else begin
                start_xfer(1'($urandom_range(0, 1)));
                finish_xfer("rnd");
            end
        end
        stall_en = 1'b0;

        // Reset in the middle of a read burst
        rd_plan.push_back($urandom);
        rd_plan.push_back($urandom);
        prog(32'h00004000, 8'h20, 6'd7);
        start_xfer(1'b0);
        idle(20);
        bus_rd(C_STAT, d); check("pre_rst_busy", {31'h0, d[0]}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) rd_src.push_back($urandom);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_rd_en", {31'h0, mig_rd_en}, 32'h0);
        check("rst_mid_data_o", data_o, 32'h0);
        rd_src.delete();
        bus_rd(C_STAT, d); check("rst_mid_status", d, 32'h0);
        bus_rd(C_ADDR, d); check("rst_mid_addr", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
